// File: rtl/mbs_fsk_pkg.sv
// mbs_fsk_pkg
// Shared definitions for the M-ary FSK generator:
//   state_e      - controller states (IDLE, LOAD, RUN)
//   half_period  - tone half-period in clock cycles for a given symbol value
package mbs_fsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Each symbol value lengthens the half-period by a fixed step above the base.
  function automatic int unsigned half_period(input int unsigned base,
                                              input int unsigned step,
                                              input int unsigned sym);
    return base + step * sym;
  endfunction

endpackage

// File: rtl/mbs_fsk_lfsr.sv
// mbs_fsk_lfsr
// Fibonacci PRBS generator used as the internal symbol source.
// Ports:
//   clk        - clock
//   reset_n    - asynchronous active-low reset, loads LFSR_SEED
//   advance    - step the register once this cycle
//   value      - current register contents
//   value_next - contents after this cycle's step (equals value when not advancing)
module mbs_fsk_lfsr #(
  parameter int unsigned        LFSR_W    = 5,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS = 5'b10100,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = 5'b00001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              advance,
  output logic [LFSR_W-1:0] value,
  output logic [LFSR_W-1:0] value_next
);

  logic [LFSR_W-1:0] value_q, value_d;

  // Shift left, feeding the parity of the tapped bits into bit 0. An all-zero
  // register can never leave that state, so a step from zero reloads the seed.
  always_comb begin
    value_d = value_q;
    if (advance) begin
      if (value_q == '0) begin
        value_d = LFSR_SEED;
      end else begin
        value_d = {value_q[LFSR_W-2:0], ^(value_q & LFSR_TAPS)};
      end
    end
  end

  // PRBS state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= LFSR_SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value      = value_q;
  assign value_next = value_d;

endmodule

// File: rtl/mbs_fsk_gen.sv
// mbs_fsk_gen
// Continuous-phase M-ary FSK tone generator. Each symbol lasts SYM_CYCLES
// clocks; tone_out is a square wave whose half-period is
// HALF_BASE + HALF_STEP*symbol. Symbols come from an external valid/ready
// offer or, when built with MBS_FSK_PRBS_EN defined, optionally from an
// internal PRBS selected by src_sel. Without MBS_FSK_PRBS_EN the PRBS is
// absent, src_sel is ignored and lfsr reads 0.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   enable                - run request; low returns to IDLE
//   src_sel               - 0 external symbols, 1 internal PRBS (sampled at fetch)
//   sym_valid, sym_data   - external symbol offer
//   sym_ready             - accept strobe on external fetch cycles
//   tone_out              - FSK waveform
//   shift                 - one-cycle pulse on every symbol fetch
//   underrun              - one-cycle pulse when an external fetch finds no symbol
//   lfsr                  - PRBS state
//   count                 - cycle position inside the current symbol
module mbs_fsk_gen
  import mbs_fsk_pkg::*;
#(
  parameter int unsigned       LFSR_W       = 5,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = 5'b10100,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 5'b00001,
  parameter int unsigned       BITS_PER_SYM = 1,
  parameter int unsigned       CNT_W        = 7,
  parameter int unsigned       HALF_BASE    = 8,
  parameter int unsigned       HALF_STEP    = 4,
  parameter int unsigned       SYM_CYCLES   = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    src_sel,
  input  logic                    sym_valid,
  input  logic [BITS_PER_SYM-1:0] sym_data,
  output logic                    sym_ready,
  output logic                    tone_out,
  output logic                    shift,
  output logic                    underrun,
  output logic [LFSR_W-1:0]       lfsr,
  output logic [CNT_W-1:0]        count
);

  localparam int unsigned M = 1 << BITS_PER_SYM;

  // Reject parameter sets whose longest half-period or symbol length cannot
  // be held in the counters.
  if (LFSR_W < 3 || LFSR_W > 16 || BITS_PER_SYM < 1 || BITS_PER_SYM > 3 ||
      BITS_PER_SYM > LFSR_W || LFSR_SEED == '0 || LFSR_TAPS == '0 ||
      HALF_BASE < 1 || SYM_CYCLES < 1 ||
      HALF_BASE + HALF_STEP * (M - 1) >= (1 << CNT_W) ||
      SYM_CYCLES > (1 << CNT_W)) begin : gBadParams
    $error("mbs_fsk_gen: illegal parameter combination");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        toneCnt_q, toneCnt_d;
  logic                    tone_q, tone_d;
  logic [BITS_PER_SYM-1:0] sym_q, sym_d;
  logic [BITS_PER_SYM-1:0] newSym, lfsrSym;
  logic [CNT_W-1:0]        newReload, curReload;
  logic                    boundary, fetch, useLfsr;

  assign boundary = (state_q == ST_RUN) && (count_q == CNT_W'(SYM_CYCLES - 1));
  assign fetch    = enable && ((state_q == ST_LOAD) || boundary);

`ifdef MBS_FSK_PRBS_EN
  logic [LFSR_W-1:0] lfsrNext;
  logic              unusedLfsrNext;

  assign useLfsr = src_sel;

  mbs_fsk_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .LFSR_SEED (LFSR_SEED)
  ) uLfsr (
    .clk        (clk),
    .reset_n    (reset_n),
    .advance    (fetch && useLfsr),
    .value      (lfsr),
    .value_next (lfsrNext)
  );

  // The symbol is taken from the register value after this fetch's step.
  assign lfsrSym        = lfsrNext[BITS_PER_SYM-1:0];
  assign unusedLfsrNext = ^lfsrNext;
`else
  logic unusedSrcSel;

  assign useLfsr      = 1'b0;
  assign lfsrSym      = '0;
  assign lfsr         = '0;
  assign unusedSrcSel = src_sel;
`endif

  // A missing external symbol is replaced by symbol 0.
  assign newSym    = useLfsr ? lfsrSym : (sym_valid ? sym_data : '0);
  assign newReload = CNT_W'(half_period(HALF_BASE, HALF_STEP, 32'(newSym)) - 1);
  assign curReload = CNT_W'(half_period(HALF_BASE, HALF_STEP, 32'(sym_q)) - 1);

  // Controller and datapath next state. At a boundary the tone counter takes
  // the new symbol's half-period but tone_out keeps its level, so the phase
  // is continuous; a toggle due on that same cycle still happens.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    toneCnt_d = toneCnt_q;
    tone_d    = tone_q;
    sym_d     = sym_q;
    if (!enable) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      toneCnt_d = '0;
      tone_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_LOAD;
          count_d   = '0;
          toneCnt_d = '0;
          tone_d    = 1'b0;
        end
        ST_LOAD: begin
          state_d   = ST_RUN;
          count_d   = '0;
          sym_d     = newSym;
          toneCnt_d = newReload;
        end
        ST_RUN: begin
          count_d = boundary ? '0 : count_q + CNT_W'(1);
          if (toneCnt_q == '0) begin
            tone_d = ~tone_q;
          end
          if (boundary) begin
            sym_d     = newSym;
            toneCnt_d = newReload;
          end else if (toneCnt_q == '0) begin
            toneCnt_d = curReload;
          end else begin
            toneCnt_d = toneCnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      toneCnt_q <= '0;
      tone_q    <= 1'b0;
      sym_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      toneCnt_q <= toneCnt_d;
      tone_q    <= tone_d;
      sym_q     <= sym_d;
    end
  end

  assign shift     = fetch;
  assign sym_ready = fetch && !useLfsr;
  assign underrun  = fetch && !useLfsr && !sym_valid;
  assign tone_out  = tone_q;
  assign count     = count_q;

endmodule
